// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
// Also used by the downstream command/spawn stage.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 10417;  // 100 MHz / 9600 baud

  // Command byte that spawns a rectangle in the game logic.
  localparam logic [7:0] KEY_SPAWN = 8'h61;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
// The reset value is a parameter so an idle-high line stays idle through reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit.
// Recovers one byte per frame and strobes rx_done for one clock.
// Optional even parity is enabled by defining UART_RX_PARITY_EN.
// This adds a PARITY state and a parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] TC_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TC_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q,     state_d;
  logic [CW-1:0]        cnt_q,       cnt_d;
  logic [BW-1:0]        bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] dout_q,      dout_d;
  logic                 rx_done_q,   rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 seen_high_q, seen_high_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q,    par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Next-state and output logic for the frame receiver.
  // seen_high_q stops a held-low line (break) from being read as a new start bit.
  // It is set once a 1 is seen in IDLE or a good stop bit is sampled.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    seen_high_d  = seen_high_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (rx_s) begin
          seen_high_d = 1'b1;
        end else if (seen_high_q) begin
          seen_high_d = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (cnt_q == TC_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == TC_BIT) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == TC_BIT) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit must have an even number of ones.
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == TC_BIT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            seen_high_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              dout_d    = shift_q;
              rx_done_d = 1'b1;
            end
`else
            dout_d    = shift_q;
            rx_done_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      seen_high_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      seen_high_q  <= seen_high_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a short bit period.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Sync latency + half bit + data bits + optional parity bit + stop bit + output register.
  localparam int LAT = 2 + CPB/2 + 8*CPB + PAR*CPB + CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_both = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .dout      (dout),
    .rx_done   (rx_done),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Count pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_done) n_done++;
    if (frame_err) n_ferr++;
    if (rx_done && frame_err) n_both++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
  end

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one frame; done_cyc is the tick index (from the start bit) at which rx_done is first seen.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_flip, output int done_cyc);
    logic [10:0] bits;
    int nbits;
    int cyc;
    done_cyc = -1;
    cyc = 0;
    nbits = 10 + PAR;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (PAR == 1) begin
      bits[9]  = (^data) ^ par_flip;
      bits[10] = stop_bit;
    end else begin
      bits[9] = stop_bit;
    end
    for (int b = 0; b < nbits; b++) begin
      rx = bits[b];
      for (int c = 0; c < CPB; c++) begin
        tick();
        cyc++;
        if (rx_done && done_cyc < 0) done_cyc = cyc;
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bad;
    int dc;
    int d0, f0, p0;
    logic [7:0] keep;

    vecs[0] = '{8'h61, 1'b1, 0,   1, 0, 8'h61};
    vecs[1] = '{8'h00, 1'b1, 0,   1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,   1, 0, 8'hFF};
    vecs[3] = '{8'hA5, 1'b1, CPB, 1, 0, 8'hA5};
    vecs[4] = '{8'h3C, 1'b0, CPB, 0, 1, 8'hA5};
    vecs[5] = '{8'h61, 1'b1, 0,   1, 0, 8'h61};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) tick();
    check("reset_dout", dout, 8'h00);
    check("reset_pulses", rx_done | frame_err, 0);
    rst = 1'b0;

    bad = 0;
    repeat (3*CPB) begin
      tick();
      if (rx_done || frame_err || dout != 8'h00) bad++;
    end
    check("idle_quiet", bad, 0);

    for (int i = 0; i < 6; i++) begin
      d0 = n_done;
      f0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0, dc);
      idle(vecs[i].gap);
      check($sformatf("vec%0d_done", i), n_done - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      if (i == 0) check("latency", dc, LAT);
    end

    // Short low glitch must be rejected.
    d0 = n_done;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (5) tick();
    idle(2*CPB);
    check("glitch_done", n_done - d0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    check("glitch_dout", dout, 8'h61);

    // Break: line held low for two frame lengths gives one frame error only.
    f0 = n_ferr;
    d0 = n_done;
    rx = 1'b0;
    repeat (2*(10+PAR)*CPB) tick();
    check("break_ferr", n_ferr - f0, 1);
    check("break_done", n_done - d0, 0);
    check("break_dout", dout, 8'h61);
    idle(CPB);
    send_frame(8'hC3, 1'b1, 1'b0, dc);
    check("after_break_dout", dout, 8'hC3);
    check("after_break_done", n_done - d0, 1);
    idle(CPB);

    // Async reset during bit 4 of 0x61.
    d0 = n_done;
    keep = 8'h61;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int b = 0; b < 4; b++) begin
      rx = keep[b];
      repeat (CPB) tick();
    end
    rx = keep[4];
    repeat (CPB/2) tick();
    check("pre_rst_dout", dout, 8'hC3);
    rst = 1'b1;
    #1;
    check("rst_async_dout", dout, 8'h00);
    repeat (2) tick();
    rst = 1'b0;
    idle(2*CPB);
    check("rst_no_pulse", n_done - d0, 0);
    check("rst_dout_held", dout, 8'h00);
    send_frame(8'h55, 1'b1, 1'b0, dc);
    idle(CPB);
    check("post_rst_dout", dout, 8'h55);
    check("post_rst_done", n_done - d0, 1);
    check("post_rst_latency", dc, LAT);

`ifdef UART_RX_PARITY_EN
    d0 = n_done;
    p0 = n_perr;
    send_frame(8'h61, 1'b1, 1'b1, dc);
    idle(CPB);
    check("par_err_pulse", n_perr - p0, 1);
    check("par_err_no_done", n_done - d0, 0);
    check("par_err_dout", dout, 8'h55);
`else
    p0 = n_perr;
    check("no_parity_pulses", n_perr - p0, 0);
`endif

    check("done_ferr_overlap", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
